tage_update_sched: RTL and testbench

- Controller in front of tage_predictor's single update port.
- Buffers branch-resolution results from the back end in a small FIFO.
- Issues buffered results to the predictor one per cycle, only in cycles with no prediction lookup (lookup has priority on the single-ported tables).
- Schedules the periodic useful-counter aging pulse, alternating the aged bit lane.

---
 rtl/tage_pkg.sv | 19 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/tage_update_sched.sv | 100 ++++++++++
 tb/tb_tage_update_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tage_pkg.sv
// Shared types and defaults for the TAGE predictor and its update scheduler.
package tage_pkg;

    localparam int TAGE_IDX_W         = 32;
    localparam int TAGE_DEF_DEPTH      = 4;
    localparam int TAGE_DEF_AGE_PERIOD = 256;

    typedef struct packed {
        logic [TAGE_IDX_W-1:0] idx;
        logic                  taken;
        logic                  correct;
    } resolution_t;

    typedef enum logic {
        RUN = 1'b0,
        AGE = 1'b1
    } sched_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with valid/ready push, pop strobe and occupancy count.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  T                           push_data_i,
    input  logic                       pop_i,
    output T                           head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T                memQ [DEPTH];
    logic [PW-1:0]   wrPtrQ, wrPtrD;
    logic [PW-1:0]   rdPtrQ, rdPtrD;
    logic [CW-1:0]   countQ, countD;
    logic            doPush, doPop;

    // Ready depends only on stored occupancy, so a full FIFO refuses a push
    // even when it is being drained in the same cycle.
    assign push_ready_o = (countQ < CW'(DEPTH));
    assign empty_o      = (countQ == '0);
    assign doPush       = push_valid_i && push_ready_o;
    assign doPop        = pop_i && !empty_o;
    assign head_o       = memQ[rdPtrQ];
    assign count_o      = countQ;

    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (doPush) wrPtrD = wrPtrQ + 1'b1;
        if (doPop)  rdPtrD = rdPtrQ + 1'b1;
        if (doPush && !doPop)      countD = countQ + 1'b1;
        else if (doPop && !doPush) countD = countQ - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) memQ[wrPtrQ] <= push_data_i;
    end

endmodule

// File: rtl/tage_update_sched.sv
// Feeds buffered branch resolutions into the predictor's single update port in
// lookup-free cycles and interleaves the periodic useful-counter aging pulse.
module tage_update_sched
    import tage_pkg::*;
#(
    parameter int DEPTH      = TAGE_DEF_DEPTH,
    parameter int IDX_W      = TAGE_IDX_W,
    parameter int AGE_PERIOD = TAGE_DEF_AGE_PERIOD
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       res_valid_i,
    input  logic [IDX_W-1:0]           res_idx_i,
    input  logic                       res_taken_i,
    input  logic                       res_correct_i,
    output logic                       res_ready_o,
    input  logic                       lookup_en_i,
    output logic                       upd_en_o,
    output logic [IDX_W-1:0]           upd_idx_o,
    output logic                       upd_taken_o,
    output logic                       upd_correct_o,
    output logic                       age_en_o,
    output logic                       age_lane_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(AGE_PERIOD);

    sched_state_e   stateQ, stateD;
    logic [CNT_W-1:0] issueCntQ, issueCntD;
    logic           laneQ, laneD;
    resolution_t    pushData, headData;
    logic           fifoEmpty;
    logic           updEn, ageEn;

    assign pushData.idx     = TAGE_IDX_W'(res_idx_i);
    assign pushData.taken   = res_taken_i;
    assign pushData.correct = res_correct_i;

    sync_fifo #(
        .T     (resolution_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_valid_i (res_valid_i),
        .push_ready_o (res_ready_o),
        .push_data_i  (pushData),
        .pop_i        (updEn),
        .head_o       (headData),
        .empty_o      (fifoEmpty),
        .count_o      (count_o)
    );

    assign upd_en_o      = updEn;
    assign age_en_o      = ageEn;
    assign age_lane_o    = laneQ;
    assign upd_idx_o     = fifoEmpty ? '0 : IDX_W'(headData.idx);
    assign upd_taken_o   = !fifoEmpty && headData.taken;
    assign upd_correct_o = !fifoEmpty && headData.correct;

    // Lookups own the single-ported tables, so both strobes yield to them.
    always_comb begin
        stateD    = stateQ;
        issueCntD = issueCntQ;
        laneD     = laneQ;
        updEn     = 1'b0;
        ageEn     = 1'b0;
        case (stateQ)
            RUN: begin
                updEn = !fifoEmpty && !lookup_en_i;
                if (updEn) begin
                    issueCntD = issueCntQ + 1'b1;
                    if (issueCntQ == CNT_W'(AGE_PERIOD - 1)) stateD = AGE;
                end
            end
            AGE: begin
                ageEn = !lookup_en_i;
                if (ageEn) begin
                    laneD  = !laneQ;
                    stateD = RUN;
                end
            end
            default: stateD = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ    <= RUN;
            issueCntQ <= '0;
            laneQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            issueCntQ <= issueCntD;
            laneQ     <= laneD;
        end
    end

endmodule

// File: tb/tb_tage_update_sched.sv
// Bench for tage_update_sched: directed table, corner sequences and a random
// run checked against a queue-based reference model.
module tb_tage_update_sched;

    localparam int DEPTH      = 4;
    localparam int IDX_W      = 32;
    localparam int AGE_PERIOD = 4;
    localparam int CW         = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             resValid;
    logic [IDX_W-1:0] resIdx;
    logic             resTaken, resCorrect;
    logic             resReady;
    logic             lookupEn;
    logic             updEn;
    logic [IDX_W-1:0] updIdx;
    logic             updTaken, updCorrect;
    logic             ageEn, ageLane;
    logic [CW-1:0]    count;

    tage_update_sched #(
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .AGE_PERIOD (AGE_PERIOD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .res_valid_i   (resValid),
        .res_idx_i     (resIdx),
        .res_taken_i   (resTaken),
        .res_correct_i (resCorrect),
        .res_ready_o   (resReady),
        .lookup_en_i   (lookupEn),
        .upd_en_o      (updEn),
        .upd_idx_o     (updIdx),
        .upd_taken_o   (updTaken),
        .upd_correct_o (updCorrect),
        .age_en_o      (ageEn),
        .age_lane_o    (ageLane),
        .count_o       (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] idx;
        logic        taken;
        logic        correct;
    } ent_t;

    typedef struct {
        logic        rst, valid;
        logic [31:0] idx;
        logic        taken, correct, lookup;
        logic        chk, expUpd;
        logic [31:0] expIdx;
        logic        expTaken, expCorrect, expAge, expLane;
        int          expCount;
        logic        expReady;
    } vec_t;

    // Reference model: a plain queue plus an issue tally and an aging flag.
    ent_t mq[$];
    int   mIssued;
    bit   mInAge, mLane;
    bit   eUpd, eAge;

    int nVectors    = 0;
    int nMiscompares = 0;
    int cycleNo     = 0;

    logic             sUpd, sAge, sLane, sReady, sTaken, sCorrect;
    logic [IDX_W-1:0] sIdx;
    logic [CW-1:0]    sCount;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cycleNo, act, exp);
        end
    endtask

    task automatic checkOutput(input logic lk);
        eUpd = !mInAge && (mq.size() > 0) && !lk;
        eAge = mInAge && !lk;
        cmp("model.upd_en", 32'(sUpd), 32'(eUpd));
        cmp("model.age_en", 32'(sAge), 32'(eAge));
        cmp("model.age_lane", 32'(sLane), 32'(mLane));
        cmp("model.count", 32'(sCount), mq.size());
        cmp("model.ready", 32'(sReady), 32'(mq.size() < DEPTH));
        if (mq.size() == 0) begin
            cmp("model.idx_empty", sIdx, 32'h0);
            cmp("model.tc_empty", {30'h0, sTaken, sCorrect}, 32'h0);
        end else if (!mInAge) begin
            cmp("model.idx", sIdx, mq[0].idx);
            cmp("model.tc", {30'h0, sTaken, sCorrect}, {30'h0, mq[0].taken, mq[0].correct});
        end
    endtask

    // One clock cycle: drive at negedge, sample and check, then advance the model at posedge.
    task automatic applyStimulus(input logic r, input logic v, input logic [31:0] idx,
                                 input logic t, input logic c, input logic lk);
        @(negedge clk);
        rst = r; resValid = v; resIdx = idx; resTaken = t; resCorrect = c; lookupEn = lk;
        #1;
        sUpd = updEn; sAge = ageEn; sLane = ageLane; sReady = resReady;
        sIdx = updIdx; sTaken = updTaken; sCorrect = updCorrect; sCount = count;
        eUpd = !mInAge && (mq.size() > 0) && !lk;
        eAge = mInAge && !lk;
        if (!r) checkOutput(lk);
        @(posedge clk);
        cycleNo++;
        if (r) begin
            mq.delete();
            mIssued = 0; mInAge = 0; mLane = 0;
        end else begin
            bit canPush;
            canPush = v && (mq.size() < DEPTH);
            if (eUpd) begin
                void'(mq.pop_front());
                mIssued++;
                if (mIssued == AGE_PERIOD) begin
                    mIssued = 0;
                    mInAge = 1;
                end
            end
            if (eAge) begin
                mLane = !mLane;
                mInAge = 0;
            end
            if (canPush) mq.push_back('{idx: idx, taken: t, correct: c});
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] idx,
                                input logic t, input logic c, input logic lk,
                                input logic eu, input logic [31:0] ei, input logic et,
                                input logic ec, input logic ea, input logic el,
                                input int en, input logic er);
        vec_t x;
        x.rst = r; x.valid = v; x.idx = idx; x.taken = t; x.correct = c; x.lookup = lk;
        x.chk = !r; x.expUpd = eu; x.expIdx = ei; x.expTaken = et; x.expCorrect = ec;
        x.expAge = ea; x.expLane = el; x.expCount = en; x.expReady = er;
        return x;
    endfunction

    vec_t tbl[16];
    logic [31:0] got[$];

    initial begin
        rst = 1'b1; resValid = 0; resIdx = '0; resTaken = 0; resCorrect = 0; lookupEn = 0;
        mq.delete(); mIssued = 0; mInAge = 0; mLane = 0;

        //           rst v  idx    t  c  lk   upd idx    t  c  age lane cnt rdy
        tbl[0]  = mk(1, 0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(0, 1, 32'h40, 1, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 32'h0,  0, 0, 0,   1, 32'h40, 1, 0, 0, 0, 1, 1);
        tbl[3]  = mk(0, 0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(0, 1, 32'h11, 0, 1, 1,   0, 32'h0,  0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 1, 32'h12, 1, 1, 1,   0, 32'h11, 0, 1, 0, 0, 1, 1);
        tbl[7]  = mk(0, 1, 32'h13, 0, 0, 1,   0, 32'h11, 0, 1, 0, 0, 2, 1);
        tbl[8]  = mk(0, 1, 32'h14, 1, 0, 1,   0, 32'h11, 0, 1, 0, 0, 3, 1);
        tbl[9]  = mk(0, 1, 32'h15, 1, 1, 1,   0, 32'h11, 0, 1, 0, 0, 4, 0);
        tbl[10] = mk(0, 0, 32'h0,  0, 0, 0,   1, 32'h11, 0, 1, 0, 0, 4, 0);
        tbl[11] = mk(0, 0, 32'h0,  0, 0, 0,   1, 32'h12, 1, 1, 0, 0, 3, 1);
        tbl[12] = mk(0, 0, 32'h0,  0, 0, 0,   1, 32'h13, 0, 0, 0, 0, 2, 1);
        tbl[13] = mk(0, 0, 32'h0,  0, 0, 0,   1, 32'h14, 1, 0, 0, 0, 1, 1);
        tbl[14] = mk(0, 0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 1, 0, 0, 1);
        tbl[15] = mk(0, 0, 32'h0,  0, 0, 0,   0, 32'h0,  0, 0, 0, 1, 0, 1);

        $display("[TB] directed table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].idx, tbl[i].taken,
                          tbl[i].correct, tbl[i].lookup);
            if (tbl[i].chk) begin
                cmp($sformatf("tbl[%0d].upd_en", i), 32'(sUpd), 32'(tbl[i].expUpd));
                cmp($sformatf("tbl[%0d].idx", i), sIdx, tbl[i].expIdx);
                cmp($sformatf("tbl[%0d].tc", i), {30'h0, sTaken, sCorrect},
                    {30'h0, tbl[i].expTaken, tbl[i].expCorrect});
                cmp($sformatf("tbl[%0d].age", i), {30'h0, sAge, sLane},
                    {30'h0, tbl[i].expAge, tbl[i].expLane});
                cmp($sformatf("tbl[%0d].count", i), 32'(sCount), tbl[i].expCount);
                cmp($sformatf("tbl[%0d].ready", i), 32'(sReady), 32'(tbl[i].expReady));
            end
        end

        $display("[TB] alternating lookup with three buffered entries");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h21, 1, 0, 1);
        applyStimulus(0, 1, 32'h22, 0, 1, 1);
        applyStimulus(0, 1, 32'h23, 1, 1, 1);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, 0, (i % 2 == 0));
            if (sUpd) got.push_back(sIdx);
        end
        cmp("alt.n_updates", got.size(), 3);
        if (got.size() == 3) begin
            cmp("alt.order0", got[0], 32'h21);
            cmp("alt.order1", got[1], 32'h22);
            cmp("alt.order2", got[2], 32'h23);
        end

        $display("[TB] aging stalled by lookup");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h31, 0, 0, 0);
        applyStimulus(0, 1, 32'h32, 0, 0, 0);
        applyStimulus(0, 1, 32'h33, 0, 0, 0);
        applyStimulus(0, 1, 32'h34, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'h35 + 32'(i), 1, 1, 1);
            cmp("stall.age_en", 32'(sAge), 32'h0);
            cmp("stall.upd_en", 32'(sUpd), 32'h0);
            cmp("stall.ready", 32'(sReady), 32'h1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        cmp("stall.age_fire", {30'h0, sAge, sLane}, 32'h2);
        cmp("stall.count", 32'(sCount), 32'h3);
        cmp("stall.upd_blocked", 32'(sUpd), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        cmp("stall.resume_upd", 32'(sUpd), 32'h1);
        cmp("stall.resume_idx", sIdx, 32'h35);
        cmp("stall.lane_toggled", 32'(sLane), 32'h1);

        $display("[TB] reset while aging with buffered entries");
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h41 + 32'(i), 0, 1, 0);
        applyStimulus(0, 1, 32'h46, 1, 0, 1);
        applyStimulus(0, 1, 32'h47, 1, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        cmp("rstage.pre_count", 32'(sCount), 32'h3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        cmp("rstage.count", 32'(sCount), 32'h0);
        cmp("rstage.upd_en", 32'(sUpd), 32'h0);
        cmp("rstage.age", {30'h0, sAge, sLane}, 32'h0);
        cmp("rstage.ready", 32'(sReady), 32'h1);

        $display("[TB] random traffic against reference model");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 249) == 0),
                          ($urandom_range(0, 9) < 6),
                          $urandom(),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
